// File: rtl/dht_reader_core.sv
// dht_reader_core: single-wire DHT11/DHT22 sensor reader with retries, holdoff and auto-trigger
// Ports:
//   i_clk        system clock, all logic on rising edge
//   i_rst_n      asynchronous active-low reset
//   i_start      one-cycle read request (ignored while busy)
//   i_mode       0 = DHT11 (18 ms start pulse), 1 = DHT22 (1 ms start pulse)
//   i_dht_in     raw line level, asynchronous
//   o_dht_oe     1 = pull line low, 0 = release to pull-up
//   o_busy       high from accepted start until done/err pulse
//   o_data       last good frame {H_i,H_d,T_i,T_d,CRC}
//   o_hum        humidity, 0.1 %RH
//   o_temp       signed temperature, 0.1 degC
//   o_done       one-cycle pulse on good read
//   o_err        one-cycle pulse when a read finally fails
//   o_err_code   01 no response, 10 bit timeout, 11 checksum
module dht_reader_core #(
    parameter int CLK_HZ         = 100_000_000,
    parameter int BIT1_THRESH_US = 48,
    parameter int TIMEOUT_US     = 200,
    parameter int RETRIES        = 2,
    parameter int HOLDOFF_MS     = 2000,
    parameter int AUTO_PERIOD_MS = 0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_mode,
    input  logic        i_dht_in,
    output logic        o_dht_oe,
    output logic        o_busy,
    output logic [39:0] o_data,
    output logic [15:0] o_hum,
    output logic [15:0] o_temp,
    output logic        o_done,
    output logic        o_err,
    output logic [1:0]  o_err_code
);
    localparam int          TICK_DIV = (CLK_HZ / 1_000_000 < 1) ? 1 : CLK_HZ / 1_000_000;
    localparam int          DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [31:0] HOLD_US  = 32'(HOLDOFF_MS * 1000);
    localparam logic [31:0] AUTO_US  = 32'((AUTO_PERIOD_MS == 0 ? 1 : AUTO_PERIOD_MS) * 1000);
    localparam logic [31:0] TMO_US   = 32'(TIMEOUT_US);
    localparam logic [31:0] THR_US   = 32'(BIT1_THRESH_US);
    localparam logic [7:0]  MAX_TRY  = 8'(RETRIES);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_START_LOW = 4'd1;
    localparam logic [3:0] S_WAIT_RESP = 4'd2;
    localparam logic [3:0] S_RESP_LOW  = 4'd3;
    localparam logic [3:0] S_RESP_HIGH = 4'd4;
    localparam logic [3:0] S_BIT_LOW   = 4'd5;
    localparam logic [3:0] S_BIT_HIGH  = 4'd6;
    localparam logic [3:0] S_CHECK     = 4'd7;
    localparam logic [3:0] S_HOLDOFF   = 4'd8;

    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_sync;
    logic [31:0]      r_auto;
    logic [3:0]       r_state;
    logic [31:0]      r_us;
    logic [39:0]      r_shift;
    logic [5:0]       r_nbits;
    logic [7:0]       r_tries;
    logic             r_mode, r_pend, r_pend_mode, r_retry, r_busy, r_oe, r_done, r_err;
    logic [1:0]       r_err_code;
    logic [39:0]      r_data;
    logic [15:0]      r_hum, r_temp;

    logic        w_tick, w_line, w_auto, w_req, w_tmo, w_hold_end, w_new, w_fail;
    logic [3:0]  w_next;
    logic [1:0]  w_code;
    logic [31:0] w_start_us;
    logic [7:0]  w_hi, w_hd, w_ti, w_td, w_sum;
    logic [15:0] w_hum, w_temp;

    assign w_tick     = (r_div == DIV_W'(TICK_DIV - 1));
    assign w_line     = r_sync[1];
    assign w_auto     = (AUTO_PERIOD_MS != 0) && w_tick && (r_auto == AUTO_US - 32'd1);
    // a start coinciding with an auto-trigger merges into one request
    assign w_req      = i_start | w_auto;
    assign w_tmo      = (r_us >= TMO_US);
    assign w_start_us = r_mode ? 32'd1000 : 32'd18000;
    assign w_hold_end = (r_state == S_HOLDOFF) && w_tick && (r_us >= HOLD_US - 32'd1);
    // a new read is accepted from IDLE, or when a non-retry holdoff ends with a request pending
    assign w_new      = ((r_state == S_IDLE) && w_req) || (w_hold_end && !r_retry && (r_pend || w_req));

    assign {w_hi, w_hd, w_ti, w_td} = r_shift[39:8];
    assign w_sum  = w_hi + w_hd + w_ti + w_td;
    assign w_hum  = r_mode ? {w_hi, w_hd} : {8'd0, w_hi} * 16'd10;
    assign w_temp = r_mode ? (w_ti[7] ? 16'd0 - {1'b0, w_ti[6:0], w_td} : {w_ti, w_td})
                           : {8'd0, w_ti} * 16'd10;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div  <= '0;
            r_sync <= 2'b11;
            r_auto <= '0;
        end else begin
            r_div  <= w_tick ? '0 : r_div + 1'b1;
            r_sync <= {r_sync[0], i_dht_in};
            if (w_tick) r_auto <= (r_auto == AUTO_US - 32'd1) ? '0 : r_auto + 32'd1;
        end
    end

    always_comb begin
        w_next = r_state;
        w_fail = 1'b0;
        w_code = 2'b01;
        case (r_state)
            S_IDLE:      w_next = w_req ? S_START_LOW : S_IDLE;
            S_START_LOW: w_next = (w_tick && r_us == w_start_us - 32'd1) ? S_WAIT_RESP : S_START_LOW;
            // the first few us are skipped so our own released low is not mistaken for a response
            S_WAIT_RESP: begin
                w_fail = w_tmo;
                w_next = (!w_line && r_us >= 32'd4) ? S_RESP_LOW : S_WAIT_RESP;
            end
            S_RESP_LOW: begin
                w_fail = w_tmo;
                w_next = w_line ? S_RESP_HIGH : S_RESP_LOW;
            end
            S_RESP_HIGH: begin
                w_fail = w_tmo;
                w_next = w_line ? S_RESP_HIGH : S_BIT_LOW;
            end
            S_BIT_LOW: begin
                w_fail = w_tmo;
                w_code = 2'b10;
                w_next = w_line ? S_BIT_HIGH : S_BIT_LOW;
            end
            S_BIT_HIGH: begin
                w_fail = w_tmo;
                w_code = 2'b10;
                w_next = w_line ? S_BIT_HIGH : (r_nbits == 6'd39 ? S_CHECK : S_BIT_LOW);
            end
            S_CHECK: begin
                w_fail = (w_sum != r_shift[7:0]);
                w_code = 2'b11;
                w_next = S_HOLDOFF;
            end
            S_HOLDOFF:   w_next = !w_hold_end ? S_HOLDOFF : ((r_retry || r_pend || w_req) ? S_START_LOW : S_IDLE);
            default:     w_next = S_IDLE;
        endcase
        if (w_fail) w_next = S_HOLDOFF;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_us        <= '0;
            r_shift     <= '0;
            r_nbits     <= '0;
            r_tries     <= '0;
            r_mode      <= 1'b0;
            r_pend      <= 1'b0;
            r_pend_mode <= 1'b0;
            r_retry     <= 1'b0;
            r_busy      <= 1'b0;
            r_oe        <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= 2'b00;
            r_data      <= '0;
            r_hum       <= '0;
            r_temp      <= '0;
        end else begin
            r_state <= w_next;
            r_us    <= (w_next != r_state) ? '0 : r_us + {31'd0, w_tick};
            r_oe    <= (w_next == S_START_LOW);
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            if (w_new) begin
                r_busy  <= 1'b1;
                r_tries <= '0;
                r_pend  <= 1'b0;
                r_mode  <= r_pend ? r_pend_mode : i_mode;
            end else if (r_state == S_HOLDOFF && !r_busy && w_req && !r_pend) begin
                r_pend      <= 1'b1;
                r_pend_mode <= i_mode;
            end
            if (w_hold_end) r_retry <= 1'b0;
            if (w_next == S_START_LOW && r_state != S_START_LOW) begin
                r_shift <= '0;
                r_nbits <= '0;
            end
            if (r_state == S_BIT_HIGH && !w_line && !w_fail) begin
                r_shift <= {r_shift[38:0], r_us > THR_US};
                r_nbits <= r_nbits + 6'd1;
            end
            if (w_fail) begin
                if (r_tries < MAX_TRY) begin
                    r_tries <= r_tries + 8'd1;
                    r_retry <= 1'b1;
                end else begin
                    r_err      <= 1'b1;
                    r_err_code <= w_code;
                    r_busy     <= 1'b0;
                end
            end else if (r_state == S_CHECK) begin
                r_done <= 1'b1;
                r_busy <= 1'b0;
                r_data <= r_shift;
                r_hum  <= w_hum;
                r_temp <= w_temp;
            end
        end
    end

    assign o_dht_oe   = r_oe;
    assign o_busy     = r_busy;
    assign o_data     = r_data;
    assign o_hum      = r_hum;
    assign o_temp     = r_temp;
    assign o_done     = r_done;
    assign o_err      = r_err;
    assign o_err_code = r_err_code;
endmodule

// File: tb/tb_dht_reader_core.sv
// tb_dht_reader_core: sensor-model bench for dht_reader_core with a frame-level reference model
`timescale 1ns/1ps
module tb_dht_reader_core;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, mode = 1'b0;
    logic        oe, busy, done, err, dht_in;
    logic [39:0] data;
    logic [15:0] hum, temp;
    logic [1:0]  err_code;
    logic        sens_low = 1'b0;
    int          n_checks = 0, n_errors = 0, cyc = 0;

    logic [39:0] s_frame = '0;
    int          s_nsend = 40, s_idx = 0;
    bit          s_silent = 1'b1, s_jit = 1'b0, s_active = 1'b0;

    int          last_done_cyc = -100000;
    logic [39:0] last_data = '0;
    logic [15:0] last_hum = '0, last_temp = '0;

    assign dht_in = !(oe || sens_low);

    dht_reader_core #(.CLK_HZ(1_000_000), .HOLDOFF_MS(1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_mode(mode), .i_dht_in(dht_in),
        .o_dht_oe(oe), .o_busy(busy), .o_data(data), .o_hum(hum), .o_temp(temp),
        .o_done(done), .o_err(err), .o_err_code(err_code)
    );

    always #500 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // sensor: answers every released start pulse with response + s_nsend bits
    always begin
        int d;
        @(posedge oe);
        @(negedge oe);
        if (!s_silent) begin
            s_active = 1'b1;
            #30000 sens_low = 1'b1;
            #80000 sens_low = 1'b0;
            #80000;
            for (int i = 0; i < s_nsend; i++) begin
                s_idx = i;
                sens_low = 1'b1;
                #50000 sens_low = 1'b0;
                d = s_frame[39-i] ? 70000 : 26500;
                if (s_jit) d = d + int'($urandom_range(6000)) - 3000;
                #(d);
            end
            if (s_nsend == 40) begin
                sens_low = 1'b1;
                #50000 sens_low = 1'b0;
            end
            s_active = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [39:0] rand_frame();
        int b[4];
        for (int i = 0; i < 4; i++) b[i] = int'($urandom_range(255));
        return {8'(b[0]), 8'(b[1]), 8'(b[2]), 8'(b[3]), 8'((b[0] + b[1] + b[2] + b[3]) % 256)};
    endfunction

    task automatic run_read(input string tag, input logic m, input logic [39:0] f, input int ns,
                            input bit sil, input bit jit, input bit poke, input bit chk_gap);
        int b[5];
        int t, pulses = 0, first_rise = -1, rise = 0, fall = 0;
        int pwmin = 1 << 30, pwmax = 0, gmin = 1 << 30, exp_pw;
        bit pass, prev_oe = 1'b0, got = 1'b0;
        logic [1:0]  ecode;
        logic [15:0] eh, et;
        for (int i = 0; i < 5; i++) b[i] = int'(f[39-8*i -: 8]);
        ecode = sil ? 2'b01 : (ns < 40) ? 2'b10 : (((b[0] + b[1] + b[2] + b[3]) % 256) != b[4]) ? 2'b11 : 2'b00;
        pass = (ecode == 2'b00);
        if (m) begin
            eh = 16'(b[0] * 256 + b[1]);
            t = (b[2] % 128) * 256 + b[3];
            if (b[2] >= 128) t = -t;
            et = 16'(t);
        end else begin
            eh = 16'(b[0] * 10);
            et = 16'(b[2] * 10);
        end
        exp_pw = m ? 1000 : 18000;
        s_frame = f; s_nsend = ns; s_silent = sil; s_jit = jit;
        @(negedge clk);
        start = 1'b1;
        mode = m;
        for (int k = 0; k < 40000 && !got; k++) begin
            @(negedge clk);
            start = poke && k == 4000;
            mode = (poke && k == 4000) ? ~m : m;
            if (poke && k == 4000) check({tag, ".busy_mid"}, busy, 1);
            if (oe && !prev_oe) begin
                pulses++;
                if (pulses == 1) first_rise = cyc;
                else gmin = (cyc - fall < gmin) ? cyc - fall : gmin;
                rise = cyc;
            end
            if (!oe && prev_oe) begin
                fall = cyc;
                pwmin = (cyc - rise < pwmin) ? cyc - rise : pwmin;
                pwmax = (cyc - rise > pwmax) ? cyc - rise : pwmax;
            end
            prev_oe = oe;
            got = done || err;
        end
        check({tag, ".finished"}, got, 1);
        check({tag, ".done"}, done, pass);
        check({tag, ".err"}, err, !pass);
        check({tag, ".busy_end"}, busy, 0);
        if (!pass) check({tag, ".err_code"}, err_code, ecode);
        if (pass) begin
            last_data = f; last_hum = eh; last_temp = et;
        end
        check({tag, ".data"}, data, last_data);
        check({tag, ".hum"}, hum, last_hum);
        check({tag, ".temp"}, temp, last_temp);
        check({tag, ".pulses"}, pulses, pass ? 1 : 3);
        check({tag, ".pulse_width"}, pwmin >= exp_pw - 1 && pwmax <= exp_pw + 1, 1);
        if (!pass) check({tag, ".retry_gap"}, gmin >= 1000, 1);
        if (chk_gap) check({tag, ".holdoff"}, first_rise - last_done_cyc >= 999, 1);
        last_done_cyc = cyc;
        @(negedge clk);
        check({tag, ".one_cycle"}, done || err, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst.oe", oe, 0);
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.err", err, 0);
        check("rst.err_code", err_code, 0);
        check("rst.data", data, 0);
        check("rst.hum", hum, 0);
        check("rst.temp", temp, 0);
        rst_n = 1'b1;
        s_silent = 1'b0;
        run_read("dht22", 1'b1, 40'h49521B2DE3, 40, 0, 0, 1, 0);
        run_read("dht11", 1'b0, 40'h49521B2DE3, 40, 0, 0, 0, 0);
        run_read("neg", 1'b1, 40'h028C806573, 40, 0, 0, 0, 1);
        run_read("silent", 1'b1, 40'h0, 40, 1, 0, 0, 0);
        run_read("crc", 1'b1, 40'h49521B2DE4, 40, 0, 0, 0, 0);
        run_read("bit17", 1'b1, 40'h49521B2DE3, 17, 0, 0, 0, 0);
        // reset during BIT_HIGH
        s_frame = rand_frame(); s_nsend = 40; s_silent = 1'b0; s_jit = 1'b1;
        @(negedge clk);
        start = 1'b1;
        mode = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 20000 && !(s_active && s_idx == 5 && !sens_low); k++) @(negedge clk);
        check("rst_mid.reached", s_active && s_idx == 5, 1);
        repeat (5) @(negedge clk);
        #200 rst_n = 1'b0;
        #1;
        check("rst_mid.oe", oe, 0);
        check("rst_mid.busy", busy, 0);
        repeat (3) @(negedge clk);
        check("rst_mid.outs", {done, err, err_code, data}, 0);
        check("rst_mid.hum_temp", {hum, temp}, 0);
        rst_n = 1'b1;
        last_data = '0; last_hum = '0; last_temp = '0;
        for (int k = 0; k < 10000 && s_active; k++) @(negedge clk);
        run_read("rnd0", 1'b1, rand_frame(), 40, 0, 1, 0, 0);
        run_read("rnd1", 1'b1, rand_frame(), 40, 0, 1, 0, 1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
